// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: X/Y counters, line/frame strobes, and
// sync/colour outputs delayed to match a renderer with PIPE_DELAY cycles of latency.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 800,
    parameter int H_FRONT    = 40,
    parameter int H_SYNC     = 128,
    parameter int H_BACK     = 88,
    parameter int V_VISIBLE  = 600,
    parameter int V_FRONT    = 1,
    parameter int V_SYNC     = 4,
    parameter int V_BACK     = 23,
    parameter bit HS_POL     = 1'b1,
    parameter bit VS_POL     = 1'b1,
    parameter int H_BITS     = 11,
    parameter int V_BITS     = 10,
    parameter int COLOR_BITS = 8,
    parameter int PIPE_DELAY = 0
) (
    input  logic                  CLK_40M,
    input  logic                  RESET_N,
    input  logic [COLOR_BITS-1:0] COLOR_IN,
    output logic [H_BITS-1:0]     X,
    output logic [V_BITS-1:0]     Y,
    output logic                  ACTIVE,
    output logic                  LINE_START,
    output logic                  FRAME_START,
    output logic                  HSYNC,
    output logic                  VSYNC,
    output logic [COLOR_BITS-1:0] COLOR
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = H_VISIBLE + H_FRONT + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = V_VISIBLE + V_FRONT + V_SYNC;
    localparam logic [H_BITS-1:0] H_LAST = H_BITS'(H_TOTAL - 1);
    localparam logic [V_BITS-1:0] V_LAST = V_BITS'(V_TOTAL - 1);

    if (H_TOTAL > (1 << H_BITS)) begin : g_h_bits_check
        $error("H_BITS too narrow for H_TOTAL-1");
    end
    if (V_TOTAL > (1 << V_BITS)) begin : g_v_bits_check
        $error("V_BITS too narrow for V_TOTAL-1");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 15) begin : g_delay_check
        $error("PIPE_DELAY must be in 0..15");
    end

    logic [H_BITS-1:0]     x_reg, x_next;
    logic [V_BITS-1:0]     y_reg, y_next;
    logic                  run_reg;
    logic                  active_reg, line_start_reg, frame_start_reg;
    logic                  hsync_reg, vsync_reg;
    logic [COLOR_BITS-1:0] color_reg;
    logic                  hs_raw, vs_raw;
    logic [2:0]            raw_bits;   // {active, vs, hs}
    logic [2:0]            tap_bits;

    // The first running edge presents (0,0); later edges advance the raster.
    always_comb begin
        x_next = '0;
        y_next = '0;
        if (run_reg) begin
            if (x_reg == H_LAST) begin
                x_next = '0;
                y_next = (y_reg == V_LAST) ? '0 : y_reg + V_BITS'(1);
            end else begin
                x_next = x_reg + H_BITS'(1);
                y_next = y_reg;
            end
        end
    end

    always_ff @(posedge CLK_40M) begin
        if (!RESET_N) begin
            x_reg           <= '0;
            y_reg           <= '0;
            run_reg         <= 1'b0;
            active_reg      <= 1'b0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            x_reg           <= x_next;
            y_reg           <= y_next;
            run_reg         <= 1'b1;
            active_reg      <= (32'(x_next) < H_VISIBLE) && (32'(y_next) < V_VISIBLE);
            line_start_reg  <= (x_next == '0);
            frame_start_reg <= (x_next == '0) && (y_next == '0);
        end
    end

    always_comb begin
        hs_raw   = (32'(x_reg) >= HS_START) && (32'(x_reg) < HS_END);
        vs_raw   = (32'(y_reg) >= VS_START) && (32'(y_reg) < VS_END);
        raw_bits = {active_reg, vs_raw, hs_raw};
    end

    if (PIPE_DELAY == 0) begin : g_no_pipe
        assign tap_bits = raw_bits;
    end else begin : g_pipe
        logic [2:0] stage_reg [PIPE_DELAY];

        // Stages hold polarity-free bits, so all-zero is the idle state.
        always_ff @(posedge CLK_40M) begin
            if (!RESET_N) begin
                for (int i = 0; i < PIPE_DELAY; i++) begin
                    stage_reg[i] <= '0;
                end
            end else begin
                stage_reg[0] <= raw_bits;
                for (int i = 1; i < PIPE_DELAY; i++) begin
                    stage_reg[i] <= stage_reg[i-1];
                end
            end
        end

        assign tap_bits = stage_reg[PIPE_DELAY-1];
    end

    always_ff @(posedge CLK_40M) begin
        if (!RESET_N) begin
            hsync_reg <= ~HS_POL;
            vsync_reg <= ~VS_POL;
            color_reg <= '0;
        end else begin
            hsync_reg <= tap_bits[0] ? HS_POL : ~HS_POL;
            vsync_reg <= tap_bits[1] ? VS_POL : ~VS_POL;
            color_reg <= tap_bits[2] ? COLOR_IN : '0;
        end
    end

    assign X           = x_reg;
    assign Y           = y_reg;
    assign ACTIVE      = active_reg;
    assign LINE_START  = line_start_reg;
    assign FRAME_START = frame_start_reg;
    assign HSYNC       = hsync_reg;
    assign VSYNC       = vsync_reg;
    assign COLOR       = color_reg;

endmodule
